vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA timing and pixel-fetch controller.
// The h/v counters feed stage A, which registers the RAM address, the read
// strobe and the frame/line strobes. A delay line of RD_LATENCY stages
// carries the timing bits alongside the RAM read. Stage C then registers
// sync, de and colour at the pins, so every pin output is aligned.
// Pin latency from the counters is RD_LATENCY + 2 cycles.
module vga_timing_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_W    = 4,
  parameter int RD_LATENCY = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 10
) (
  input  logic                   vga_clk,
  input  logic                   clr,
  input  logic [3*COLOR_W-1:0]   d_in,
  output logic [ROW_W-1:0]       row_addr,
  output logic [COL_W-1:0]       col_addr,
  output logic                   rdn,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic                   hs,
  output logic                   vs,
  output logic                   de
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  // Reject timing sets that would give empty windows or unaligned scaling.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      RD_LATENCY < 0 || RD_LATENCY > 4 ||
      SCALE_LOG2 < 0 || SCALE_LOG2 > 2 ||
      (H_ACTIVE % (1 << SCALE_LOG2)) != 0 ||
      (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_param_check
    $error("vga_timing_ctrl: illegal parameter set");
  end

  logic [HCW-1:0] h_q;
  logic [VCW-1:0] v_q;

  // Stage A registers.
  logic [COL_W-1:0] col_addr_q;
  logic [ROW_W-1:0] row_addr_q;
  logic             rdn_q;
  logic             frame_start_q;
  logic             line_start_q;

  // Delay line: index 0 is captured with stage A; index RD_LATENCY feeds stage C.
  logic [RD_LATENCY:0] act_q;
  logic [RD_LATENCY:0] hsr_q;
  logic [RD_LATENCY:0] vsr_q;

  // Stage C (pin) registers.
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               hs_q, vs_q, de_q;

  // Combinational decode of the current counter position.
  logic             h_act_d, v_act_d, active_d, hsync_d, vsync_d;
  logic [HCW-1:0]   h_rel_d;
  logic [VCW-1:0]   v_rel_d;
  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_d;

  // Pixel/line counters: h wraps every line, v advances at end of line.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HCW'(H_TOTAL - 1)) begin
      h_q <= '0;
      if (v_q == VCW'(V_TOTAL - 1)) v_q <= '0;
      else                          v_q <= v_q + VCW'(1);
    end else begin
      h_q <= h_q + HCW'(1);
    end
  end

  // Window decode and scaled address generation from the counters.
  always_comb begin
    h_act_d  = (h_q >= HCW'(H_START)) && (h_q < HCW'(H_START + H_ACTIVE));
    v_act_d  = (v_q >= VCW'(V_START)) && (v_q < VCW'(V_START + V_ACTIVE));
    active_d = h_act_d && v_act_d;
    hsync_d  = (h_q < HCW'(H_SYNC));
    vsync_d  = (v_q < VCW'(V_SYNC));
    h_rel_d  = h_q - HCW'(H_START);
    v_rel_d  = v_q - VCW'(V_START);
    col_d    = COL_W'(h_rel_d >> SCALE_LOG2);
    row_d    = ROW_W'(v_rel_d >> SCALE_LOG2);
  end

  // Stage A: RAM address, read strobe and frame/line strobes.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      col_addr_q    <= '0;
      row_addr_q    <= '0;
      rdn_q         <= 1'b1;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      col_addr_q    <= active_d ? col_d : '0;
      row_addr_q    <= active_d ? row_d : '0;
      rdn_q         <= ~active_d;
      frame_start_q <= (h_q == HCW'(H_START)) && (v_q == VCW'(V_START));
      line_start_q  <= (h_q == HCW'(H_START)) && v_act_d;
    end
  end

  // Timing bits travel alongside the RAM read so colour and sync stay aligned.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      act_q <= '0;
      hsr_q <= '0;
      vsr_q <= '0;
    end else begin
      act_q[0] <= active_d;
      hsr_q[0] <= hsync_d;
      vsr_q[0] <= vsync_d;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        act_q[i] <= act_q[i-1];
        hsr_q[i] <= hsr_q[i-1];
        vsr_q[i] <= vsr_q[i-1];
      end
    end
  end

  // Stage C: pin registers; colour is blanked outside the active window.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_ACT;
      vs_q <= ~VS_ACT;
    end else begin
      de_q <= act_q[RD_LATENCY];
      hs_q <= hsr_q[RD_LATENCY] ? HS_ACT : ~HS_ACT;
      vs_q <= vsr_q[RD_LATENCY] ? VS_ACT : ~VS_ACT;
      if (act_q[RD_LATENCY]) begin
        r_q <= d_in[COLOR_W-1:0];
        g_q <= d_in[2*COLOR_W-1:COLOR_W];
        b_q <= d_in[3*COLOR_W-1:2*COLOR_W];
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign col_addr    = col_addr_q;
  assign row_addr    = row_addr_q;
  assign rdn         = rdn_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with a small timing set, read latency 2,
// 2x replication and mixed sync polarity. Expected outputs come from
// position arithmetic on the cycle count since the last reset.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 2;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 1;
  localparam int HSP = 0, VSP = 1;
  localparam int CW = 4, RDL = 2, SC = 1, COLW = 6, ROWW = 5;
  localparam int HT = HSW + HBP + HA + HFP;   // 23
  localparam int VT = VSW + VBP + VA + VFP;   // 12
  localparam int HST = HSW + HBP;
  localparam int VST = VSW + VBP;
  localparam int FR = HT * VT;                // 276 cycles per frame
  localparam int L = RDL + 2;
  localparam int MID_TGT = HT * (VST + 2) + HST + 5;

  // clock/reset block
  logic vga_clk = 1'b0;
  logic clr = 1'b1;
  logic [3*CW-1:0] d_in = '0;
  always #5 vga_clk = ~vga_clk;

  logic [ROWW-1:0] row_addr;
  logic [COLW-1:0] col_addr;
  logic rdn, frame_start, line_start, hs, vs, de;
  logic [CW-1:0] r, g, b;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CW), .RD_LATENCY(RDL),
    .SCALE_LOG2(SC), .COL_W(COLW), .ROW_W(ROWW)
  ) dut (
    .vga_clk(vga_clk), .clr(clr), .d_in(d_in),
    .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
    .frame_start(frame_start), .line_start(line_start),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de)
  );

  int n_checks = 0;
  int n_fail = 0;
  int s = -1;            // cycles since the last reset edge; -1 before any reset
  logic [11:0] mem [0:31][0:63];
  logic [ROWW+COLW:0] ahist [$];

  // aggregate counters over the first undisturbed window
  bit agg_on = 1'b0;
  int c_de = 0, c_hs = 0, c_vs = 0, c_fs = 0, c_ls = 0, c_rd = 0;

  // scoreboard check
  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (s=%0d)", tag, obs, exp, s);
    end
  endtask

  function automatic bit pos_active(input int p);
    int h, v;
    if (p < 0) return 1'b0;
    h = p % HT;
    v = (p / HT) % VT;
    return (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
  endfunction

  // reference model: expected outputs from counter positions
  task automatic check_outputs();
    int pa, pp, ha, va, hp, vp, ec, er;
    bit aa, ap;
    logic [11:0] px;
    if (s < 0) return;
    pa = s - 1;
    pp = s - L;
    aa = pos_active(pa);
    ap = pos_active(pp);
    ha = (pa < 0) ? 0 : pa % HT;
    va = (pa < 0) ? 0 : (pa / HT) % VT;
    ec = aa ? ((ha - HST) >> SC) : 0;
    er = aa ? ((va - VST) >> SC) : 0;
    check_eq("rdn", int'(rdn), aa ? 0 : 1);
    check_eq("col_addr", int'(col_addr), ec);
    check_eq("row_addr", int'(row_addr), er);
    check_eq("frame_start", int'(frame_start), (aa && ha == HST && va == VST) ? 1 : 0);
    check_eq("line_start", int'(line_start), (aa && ha == HST) ? 1 : 0);
    hp = (pp < 0) ? HST : pp % HT;
    vp = (pp < 0) ? VST : (pp / HT) % VT;
    check_eq("de", int'(de), ap ? 1 : 0);
    check_eq("hs", int'(hs), (pp >= 0 && hp < HSW) ? HSP : 1 - HSP);
    check_eq("vs", int'(vs), (pp >= 0 && vp < VSW) ? VSP : 1 - VSP);
    px = ap ? mem[((vp - VST) >> SC)][((hp - HST) >> SC)] : 12'h000;
    check_eq("rgb", int'({b, g, r}), int'(px));
    if (agg_on) begin
      c_de += int'(de);
      c_hs += (int'(hs) == HSP) ? 1 : 0;
      c_vs += (int'(vs) == VSP) ? 1 : 0;
      c_fs += int'(frame_start);
      c_ls += int'(line_start);
      c_rd += (rdn == 1'b0) ? 1 : 0;
    end
  endtask

  // driver: check at negedge, drive RAM data and clr, advance one clock
  task automatic drive_cycle(input bit rst);
    logic [ROWW+COLW:0] e;
    check_outputs();
    ahist.push_back({rdn, row_addr, col_addr});
    if (ahist.size() > RDL) begin
      e = ahist.pop_front();
      if (e[ROWW+COLW] == 1'b0) d_in = mem[e[ROWW+COLW-1:COLW]][e[COLW-1:0]];
      else                      d_in = 12'($urandom);
    end else begin
      d_in = 12'($urandom);
    end
    clr = rst;
    @(posedge vga_clk);
    if (clr) s = 0;
    else if (s >= 0) s++;
    @(negedge vga_clk);
  endtask

  initial begin
    int rst_left;
    bit mid_done;
    bit rst;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 64; j++)
        mem[i][j] = 12'($urandom);
    @(negedge vga_clk);
    // power-on style reset, then three undisturbed frames
    for (int i = 0; i < 3; i++) drive_cycle(1'b1);
    agg_on = 1'b1;
    for (int i = 0; i < 3 * FR; i++) drive_cycle(1'b0);
    agg_on = 1'b0;
    check_eq("agg_de", c_de, 3 * HA * VA);
    check_eq("agg_rdn_low", c_rd, 3 * HA * VA);
    check_eq("agg_hs_active", c_hs, 3 * VT * HSW);
    check_eq("agg_vs_active", c_vs, 3 * VSW * HT);
    check_eq("agg_frame_start", c_fs, 3);
    check_eq("agg_line_start", c_ls, 3 * VA);
    // mid-active-line reset pulse, then random reset pulses
    rst_left = 0;
    mid_done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = 1'b0;
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if (!mid_done && (s % FR) == MID_TGT) begin
        rst = 1'b1;
        mid_done = 1'b1;
      end else if (mid_done && $urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 2);
      end
      drive_cycle(rst);
    end
    check_eq("mid_reset_applied", int'(mid_done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
